cl_ocl_regfile: RTL and testbench
=================================

Name: cl_ocl_regfile

Overview:
Parametrised AXI-Lite register-file slave for the OCL BAR0 path. It sits behind the OCL AXI-L register slice.
- Provides NUM_RW software-writable control registers with byte-strobe support.
- Provides NUM_RO read-only status registers sampled from CL logic.
- Accepts AW and W independently, so either may arrive first.
- Returns OKAY, SLVERR or DECERR responses per access.

Parameters:
NUM_RW, 8, number of 32-bit read/write registers; byte offsets 0x0 .. 4*(NUM_RW-1); legal range 1..64
NUM_RO, 4, number of 32-bit read-only registers; byte offsets immediately following the RW block; legal range 0..64
ADDR_W, 16, AXI-L address bits decoded; upper address bits are ignored
RW_RST_VAL, 32'h0000_0000, reset value loaded into every RW register
UNIMPL_VAL, 32'hDEAD_BEEF, rdata returned on DECERR reads

Ports:
clk_main_a0  in  1  clock
rst_main  in  1  synchronous, active-high reset
s_awvalid  in  1  write address valid
s_awaddr  in  ADDR_W  write address
s_awready  out  1  write address ready
s_wvalid  in  1  write data valid
s_wdata  in  32  write data
s_wstrb  in  4  write byte strobes
s_wready  out  1  write data ready
s_bvalid  out  1  write response valid
s_bresp  out  2  write response
s_bready  in  1  write response ready
s_arvalid  in  1  read address valid
s_araddr  in  ADDR_W  read address
s_arready  out  1  read address ready
s_rvalid  out  1  read data valid
s_rdata  out  32  read data
s_rresp  out  2  read response
s_rready  in  1  read response ready
rw_regs  out  NUM_RW*32  flattened RW register contents; register i occupies bits [32i+31:32i]
wr_pulse  out  NUM_RW  one-cycle strobe, asserted the cycle after register i is committed
ro_regs  in  NUM_RO*32  flattened RO status inputs, sampled at read acceptance

Behaviour:
- Reset: all outputs 0, except rw_regs = RW_RST_VAL replicated. Holding registers are cleared. Reset asserted mid-transaction drops the transaction; no response is issued for it.
- Address decode uses addr[ADDR_W-1:0].
  - addr[1:0] != 0: SLVERR.
  - Index idx = addr>>2 with idx < NUM_RW: RW register.
  - NUM_RW <= idx < NUM_RW+NUM_RO: RO register.
  - Otherwise: DECERR (2'b11).
- Write channel:
  - s_awready = !aw_held && !s_bvalid; s_wready = !w_held && !s_bvalid.
  - On handshake, address or data+strobe is latched into its holding register.
  - AW and W may arrive in the same cycle or in either order, with any gap between them.
  - Commit: on the first edge at which both are held, every byte lane with wstrb[b]=1 is updated.
    - RW target: update happens, response OKAY.
    - RO target: no update, SLVERR.
    - Unaligned: no update, SLVERR.
    - Out of range: no update, DECERR.
    - wstrb = 0 to an RW register: OKAY, no update, wr_pulse still fires.
  - s_bvalid rises on the same edge as the commit, and the holding registers clear.
  - If AW and W handshake together at edge T: commit and bvalid at edge T+1.
  - s_bvalid holds until s_bready; no new AW/W is accepted while s_bvalid=1.
- Read channel:
  - s_arready = !s_rvalid.
  - On AR handshake at edge T: s_rvalid=1, s_rdata and s_rresp are registered at T.
  - Latency is 1 cycle; throughput is 1 read per 2 cycles without backpressure.
  - rdata for an RW or RO hit is the register value; UNIMPL_VAL on DECERR; 0 on SLVERR.
  - rdata and rresp stay stable until s_rready, then clear to 0.
- Concurrency:
  - Reads and writes proceed independently.
  - A read accepted on the same edge a write commits to the same register returns the pre-write value.
- wr_pulse[i] is registered: it is high for exactly the one cycle after the edge at which register i commits.

Optional Feature:
CL_OCL_REGFILE_BSWAP_EN:
- Defined: reads whose addr[ADDR_W-1]=1 decode the remaining bits as an RW index and return that register byte-swapped ({[7:0],[15:8],[23:16],[31:24]}) with OKAY. Writes to this window are DECERR.
- Undefined: the whole window decodes as DECERR for both reads and writes.

Test Plan:
- Reset, then read 0x0 -> rvalid 1 cycle after AR, rdata=RW_RST_VAL, rresp=OKAY; rw_regs all RW_RST_VAL.
- W (data 0x1234_5678, strb 4'hF) 3 cycles before AW 0x4 -> bvalid the edge after AW, bresp=OKAY, rw_regs[63:32]=0x1234_5678, wr_pulse[1] high 1 cycle.
- Write 0xAABB_CCDD strb 4'b0101 to 0x4 (holding 0x1234_5678) -> reg1=0x12BB_56DD.
- With ro_regs idx0=0xCAFE_0001, read 4*NUM_RW -> rdata=0xCAFE_0001, OKAY; write same address -> SLVERR, value unchanged.
- Read 0x2 -> SLVERR, rdata 0. Read 4*(NUM_RW+NUM_RO) -> DECERR, rdata 0xDEAD_BEEF. Hold rready=0 for 5 cycles -> rvalid, rdata stable and arready=0 throughout.
- With CL_OCL_REGFILE_BSWAP_EN, reg0=0x0102_0304, read {1'b1,0...} -> 0x0403_0201; without the macro -> DECERR.

Source files
------------

// File: rtl/cl_ocl_regfile.sv
`default_nettype none
// ============================================================================
// Module   : cl_ocl_regfile
// Brief    : AXI-Lite register-file slave for the OCL BAR0 path. Exposes
//            NUM_RW byte-strobed control registers followed by NUM_RO
//            read-only status registers. AW and W are accepted independently
//            and in either order.
// Ports    : clk_main_a0 / rst_main (sync, active-high)
//            s_aw* / s_w* / s_b*    AXI-L write address, data, response
//            s_ar* / s_r*           AXI-L read address, data
//            rw_regs   flattened RW contents, reg i at [32i+31:32i]
//            wr_pulse  one-cycle strobe the cycle after reg i commits
//            ro_regs   flattened RO status inputs, sampled at AR acceptance
// Options  : CL_OCL_REGFILE_BSWAP_EN - when defined, reads with
//            addr[ADDR_W-1]=1 return RW register (remaining index bits)
//            byte-swapped; writes there are DECERR. When undefined the
//            whole upper window is DECERR.
// Revision : 1.0 - initial release
// ============================================================================
module cl_ocl_regfile #(
    parameter int          NUM_RW     = 8,
    parameter int          NUM_RO     = 4,
    parameter int          ADDR_W     = 16,
    parameter logic [31:0] RW_RST_VAL = 32'h0000_0000,
    parameter logic [31:0] UNIMPL_VAL = 32'hDEAD_BEEF
) (
    input  logic                    clk_main_a0,
    input  logic                    rst_main,
    input  logic                    s_awvalid,
    input  logic [ADDR_W-1:0]       s_awaddr,
    output logic                    s_awready,
    input  logic                    s_wvalid,
    input  logic [31:0]             s_wdata,
    input  logic [3:0]              s_wstrb,
    output logic                    s_wready,
    output logic                    s_bvalid,
    output logic [1:0]              s_bresp,
    input  logic                    s_bready,
    input  logic                    s_arvalid,
    input  logic [ADDR_W-1:0]       s_araddr,
    output logic                    s_arready,
    output logic                    s_rvalid,
    output logic [31:0]             s_rdata,
    output logic [1:0]              s_rresp,
    input  logic                    s_rready,
    output logic [NUM_RW*32-1:0]    rw_regs,
    output logic [NUM_RW-1:0]       wr_pulse,
    // Sized to at least one word so NUM_RO=0 still yields a legal port.
    input  logic [((NUM_RO > 0) ? NUM_RO : 1)*32-1:0] ro_regs
);

    localparam logic [1:0]  c_okay   = 2'b00;
    localparam logic [1:0]  c_slverr = 2'b10;
    localparam logic [1:0]  c_decerr = 2'b11;
    localparam logic [31:0] c_rw_lim = NUM_RW;
    localparam logic [31:0] c_ro_lim = NUM_RW + NUM_RO;

    // resp==OKAY && !is_rw means an RO hit; idx is the absolute word index.
    typedef struct packed {
        logic [1:0]  resp;
        logic        is_rw;
        logic        bswap;
        logic [31:0] idx;
    } dec_t;

    function automatic dec_t f_decode(input logic [ADDR_W-1:0] addr);
        dec_t        d;
        logic [31:0] idx;
        d   = '0;
        idx = '0;
        idx[ADDR_W-3:0] = addr[ADDR_W-1:2];
        if (addr[1:0] != 2'b00) begin
            d.resp = c_slverr;
        end else if (addr[ADDR_W-1]) begin
`ifdef CL_OCL_REGFILE_BSWAP_EN
            idx[ADDR_W-3] = 1'b0;
            if (idx < c_rw_lim) begin
                d.resp  = c_okay;
                d.is_rw = 1'b1;
                d.bswap = 1'b1;
                d.idx   = idx;
            end else begin
                d.resp = c_decerr;
            end
`else
            d.resp = c_decerr;
`endif
        end else if (idx < c_rw_lim) begin
            d.resp  = c_okay;
            d.is_rw = 1'b1;
            d.idx   = idx;
        end else if (idx < c_ro_lim) begin
            d.resp = c_okay;
            d.idx  = idx;
        end else begin
            d.resp = c_decerr;
        end
        return d;
    endfunction

    // ---------------------------------------------------------------- write
    logic              r_aw_held;
    logic [ADDR_W-1:0] r_aw_addr;
    logic              r_w_held;
    logic [31:0]       r_w_data;
    logic [3:0]        r_w_strb;
    logic              r_bvalid;
    logic [1:0]        r_bresp;

    dec_t       w_wr_dec;
    logic       w_commit;
    logic       w_wr_hit;
    logic [1:0] w_wr_resp;
    logic       w_awready;
    logic       w_wready;

    assign w_wr_dec  = f_decode(r_aw_addr);
    assign w_commit  = r_aw_held && r_w_held;
    // The byte-swap alias is a read-only view.
    assign w_wr_hit  = w_wr_dec.is_rw && !w_wr_dec.bswap;
    assign w_wr_resp = w_wr_dec.bswap ? c_decerr :
                       (w_wr_dec.resp == c_okay && !w_wr_dec.is_rw) ? c_slverr :
                       w_wr_dec.resp;
    assign w_awready = !r_aw_held && !r_bvalid;
    assign w_wready  = !r_w_held && !r_bvalid;

    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            r_aw_held <= 1'b0;
            r_aw_addr <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= '0;
        end else if (w_commit) begin
            // Both readies are low while both are held, so no new beat
            // can collide with the commit.
            r_aw_held <= 1'b0;
            r_aw_addr <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wr_resp;
        end else begin
            if (r_bvalid && s_bready) begin
                r_bvalid <= 1'b0;
                r_bresp  <= '0;
            end
            if (s_awvalid && w_awready) begin
                r_aw_held <= 1'b1;
                r_aw_addr <= s_awaddr;
            end
            if (s_wvalid && w_wready) begin
                r_w_held <= 1'b1;
                r_w_data <= s_wdata;
                r_w_strb <= s_wstrb;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_rw
        logic [31:0] r_val;
        logic        r_pulse;
        always_ff @(posedge clk_main_a0) begin
            if (rst_main) begin
                r_val   <= RW_RST_VAL;
                r_pulse <= 1'b0;
            end else begin
                r_pulse <= 1'b0;
                if (w_commit && w_wr_hit && (w_wr_dec.idx == 32'(gi))) begin
                    r_pulse <= 1'b1;
                    for (int b = 0; b < 4; b++) begin
                        if (r_w_strb[b]) begin
                            r_val[8*b +: 8] <= r_w_data[8*b +: 8];
                        end
                    end
                end
            end
        end
        assign rw_regs[gi*32 +: 32] = r_val;
        assign wr_pulse[gi]         = r_pulse;
    end

    // ----------------------------------------------------------------- read
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    dec_t        w_rd_dec;
    logic [31:0] w_rd_data;
    logic [31:0] w_rd_word;
    logic        w_arready;

    assign w_rd_dec  = f_decode(s_araddr);
    assign w_arready = !r_rvalid;

    // rw_regs holds pre-commit values, so a read accepted on a commit edge
    // naturally returns the old contents.
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (w_rd_dec.is_rw && w_rd_dec.idx == 32'(i)) begin
                w_rd_word = rw_regs[i*32 +: 32];
            end
        end
        for (int i = 0; i < NUM_RO; i++) begin
            if (!w_rd_dec.is_rw && w_rd_dec.idx == c_rw_lim + 32'(i)) begin
                w_rd_word = ro_regs[i*32 +: 32];
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (w_rd_dec.resp)
            c_okay: begin
                if (w_rd_dec.bswap) begin
                    w_rd_data = {w_rd_word[7:0], w_rd_word[15:8],
                                 w_rd_word[23:16], w_rd_word[31:24]};
                end else begin
                    w_rd_data = w_rd_word;
                end
            end
            c_decerr: w_rd_data = UNIMPL_VAL;
            default:  w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= '0;
        end else if (s_arvalid && w_arready) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_dec.resp;
        end else if (r_rvalid && s_rready) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= '0;
        end
    end

    assign s_awready = w_awready;
    assign s_wready  = w_wready;
    assign s_bvalid  = r_bvalid;
    assign s_bresp   = r_bresp;
    assign s_arready = w_arready;
    assign s_rvalid  = r_rvalid;
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_cl_ocl_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_cl_ocl_regfile
// Brief    : Self-checking bench for cl_ocl_regfile (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cl_ocl_regfile;

    localparam int NUM_RW = 8;
    localparam int NUM_RO = 4;
    localparam int ADDR_W = 16;

    localparam logic [1:0] c_okay   = 2'b00;
    localparam logic [1:0] c_slverr = 2'b10;
    localparam logic [1:0] c_decerr = 2'b11;

    logic                 clk_main_a0 = 1'b0;
    logic                 rst_main    = 1'b1;
    logic                 s_awvalid   = 1'b0;
    logic [ADDR_W-1:0]    s_awaddr    = '0;
    logic                 s_awready;
    logic                 s_wvalid    = 1'b0;
    logic [31:0]          s_wdata     = '0;
    logic [3:0]           s_wstrb     = '0;
    logic                 s_wready;
    logic                 s_bvalid;
    logic [1:0]           s_bresp;
    logic                 s_bready    = 1'b1;
    logic                 s_arvalid   = 1'b0;
    logic [ADDR_W-1:0]    s_araddr    = '0;
    logic                 s_arready;
    logic                 s_rvalid;
    logic [31:0]          s_rdata;
    logic [1:0]           s_rresp;
    logic                 s_rready    = 1'b1;
    logic [NUM_RW*32-1:0] rw_regs;
    logic [NUM_RW-1:0]    wr_pulse;
    logic [NUM_RO*32-1:0] ro_regs = {32'h4444_0004, 32'h2222_0003,
                                     32'h2222_0002, 32'hCAFE_0001};

    always #5 clk_main_a0 = ~clk_main_a0;

    cl_ocl_regfile #(
        .NUM_RW     (NUM_RW),
        .NUM_RO     (NUM_RO),
        .ADDR_W     (ADDR_W),
        .RW_RST_VAL (32'h0000_0000),
        .UNIMPL_VAL (32'hDEAD_BEEF)
    ) dut (
        .clk_main_a0 (clk_main_a0),
        .rst_main    (rst_main),
        .s_awvalid   (s_awvalid),
        .s_awaddr    (s_awaddr),
        .s_awready   (s_awready),
        .s_wvalid    (s_wvalid),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_wready    (s_wready),
        .s_bvalid    (s_bvalid),
        .s_bresp     (s_bresp),
        .s_bready    (s_bready),
        .s_arvalid   (s_arvalid),
        .s_araddr    (s_araddr),
        .s_arready   (s_arready),
        .s_rvalid    (s_rvalid),
        .s_rdata     (s_rdata),
        .s_rresp     (s_rresp),
        .s_rready    (s_rready),
        .rw_regs     (rw_regs),
        .wr_pulse    (wr_pulse),
        .ro_regs     (ro_regs)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic        is_wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string n, input logic w, input logic [15:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] r, input logic [31:0] rd);
        vec_t v;
        v.name = n; v.is_wr = w; v.addr = a; v.wdata = d; v.wstrb = s;
        v.exp_resp = r; v.exp_rdata = rd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // AW and W are offered together; lat counts edges from the last
    // handshake edge to the first sample showing bvalid.
    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int lat);
        bit aw_done = 0, w_done = 0, aw_go, w_go;
        int n = 0;
        s_awvalid = 1'b1; s_awaddr = a;
        s_wvalid  = 1'b1; s_wdata  = d; s_wstrb = s;
        while (!(aw_done && w_done) && n < 20) begin
            aw_go = s_awvalid && s_awready;
            w_go  = s_wvalid && s_wready;
            @(posedge clk_main_a0); #1; n++;
            if (aw_go) begin s_awvalid = 1'b0; aw_done = 1; end
            if (w_go)  begin s_wvalid  = 1'b0; w_done  = 1; end
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        if (!(aw_done && w_done)) chk("wr_accept_timeout", 32'd0, 32'd1);
        lat = 0;
        while (!s_bvalid && lat < 20) begin @(posedge clk_main_a0); #1; lat++; end
        if (!s_bvalid) chk("bvalid_timeout", 32'd0, 32'd1);
        resp = s_bresp;
        @(posedge clk_main_a0); #1;
    endtask

    task automatic do_read(input logic [15:0] a, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        int n = 0;
        s_arvalid = 1'b1; s_araddr = a;
        while (!s_arready && n < 20) begin @(posedge clk_main_a0); #1; n++; end
        @(posedge clk_main_a0); #1;
        s_arvalid = 1'b0;
        lat = 1;
        while (!s_rvalid && lat < 20) begin @(posedge clk_main_a0); #1; lat++; end
        if (!s_rvalid) chk("rvalid_timeout", 32'd0, 32'd1);
        data = s_rdata;
        resp = s_rresp;
        @(posedge clk_main_a0); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsp;
        int          lat;
        logic [31:0] exp_rw [NUM_RW];
        bit          seen;

        // ---------------- reset
        repeat (3) @(posedge clk_main_a0);
        #1 rst_main = 1'b0;
        chk("rst_bvalid", 32'(s_bvalid), 32'd0);
        chk("rst_rvalid", 32'(s_rvalid), 32'd0);
        chk("rst_rdata", s_rdata, 32'd0);
        chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
        chk("rst_rw_zero", 32'(|rw_regs), 32'd0);

        do_read(16'h0000, rd, rsp, lat);
        chk("rd0_lat", 32'(lat), 32'd1);
        chk("rd0_data", rd, 32'd0);
        chk("rd0_resp", 32'(rsp), 32'(c_okay));

        // ---------------- W three cycles ahead of AW, with b backpressure
        s_bready = 1'b0;
        s_wvalid = 1'b1; s_wdata = 32'h1234_5678; s_wstrb = 4'hF;
        @(posedge clk_main_a0); #1 s_wvalid = 1'b0;
        repeat (2) begin @(posedge clk_main_a0); #1; end
        chk("a_no_early_b", 32'(s_bvalid), 32'd0);
        s_awvalid = 1'b1; s_awaddr = 16'h0004;
        @(posedge clk_main_a0); #1 s_awvalid = 1'b0;
        chk("a_b_not_yet", 32'(s_bvalid), 32'd0);
        @(posedge clk_main_a0); #1;
        chk("a_bvalid", 32'(s_bvalid), 32'd1);
        chk("a_bresp", 32'(s_bresp), 32'(c_okay));
        chk("a_pulse", 32'(wr_pulse), 32'h02);
        chk("a_reg1", rw_regs[63:32], 32'h1234_5678);
        @(posedge clk_main_a0); #1;
        chk("a_pulse_gone", 32'(wr_pulse), 32'h00);
        chk("a_b_hold", 32'(s_bvalid), 32'd1);
        chk("a_rdy_blocked", {30'd0, s_awready, s_wready}, 32'd0);
        s_bready = 1'b1;
        @(posedge clk_main_a0); #1;
        chk("a_b_clear", 32'(s_bvalid), 32'd0);

        // ---------------- vector table
        add_vec("w_strb5",    1, 16'h0004, 32'hAABB_CCDD, 4'b0101, c_okay,   32'h0);
        add_vec("r_reg1",     0, 16'h0004, 32'h0,         4'h0,    c_okay,   32'h12BB_56DD);
        add_vec("r_ro0",      0, 16'h0020, 32'h0,         4'h0,    c_okay,   32'hCAFE_0001);
        add_vec("w_ro0",      1, 16'h0020, 32'hFFFF_FFFF, 4'hF,    c_slverr, 32'h0);
        add_vec("r_ro0_again",0, 16'h0020, 32'h0,         4'h0,    c_okay,   32'hCAFE_0001);
        add_vec("r_ro2",      0, 16'h0028, 32'h0,         4'h0,    c_okay,   32'h2222_0003);
        add_vec("r_ro3",      0, 16'h002C, 32'h0,         4'h0,    c_okay,   32'h4444_0004);
        add_vec("r_unalign",  0, 16'h0002, 32'h0,         4'h0,    c_slverr, 32'h0);
        add_vec("w_unalign",  1, 16'h0006, 32'h5A5A_5A5A, 4'hF,    c_slverr, 32'h0);
        add_vec("r_reg1_keep",0, 16'h0004, 32'h0,         4'h0,    c_okay,   32'h12BB_56DD);
        add_vec("r_decerr",   0, 16'h0030, 32'h0,         4'h0,    c_decerr, 32'hDEAD_BEEF);
        add_vec("w_decerr",   1, 16'h0030, 32'h1111_1111, 4'hF,    c_decerr, 32'h0);
        add_vec("w_reg7",     1, 16'h001C, 32'h89AB_CDEF, 4'hF,    c_okay,   32'h0);
        add_vec("r_reg7",     0, 16'h001C, 32'h0,         4'h0,    c_okay,   32'h89AB_CDEF);
        add_vec("w_reg7_s0",  1, 16'h001C, 32'h0000_0000, 4'h0,    c_okay,   32'h0);
        add_vec("r_reg7_keep",0, 16'h001C, 32'h0,         4'h0,    c_okay,   32'h89AB_CDEF);
        add_vec("w_reg0",     1, 16'h0000, 32'h0102_0304, 4'hF,    c_okay,   32'h0);
`ifdef CL_OCL_REGFILE_BSWAP_EN
        add_vec("r_bswap0",   0, 16'h8000, 32'h0,         4'h0,    c_okay,   32'h0403_0201);
        add_vec("r_bswap1",   0, 16'h8004, 32'h0,         4'h0,    c_okay,   32'hDD56_BB12);
`else
        add_vec("r_bswap0",   0, 16'h8000, 32'h0,         4'h0,    c_decerr, 32'hDEAD_BEEF);
        add_vec("r_bswap1",   0, 16'h8004, 32'h0,         4'h0,    c_decerr, 32'hDEAD_BEEF);
`endif
        add_vec("w_bswap",    1, 16'h8000, 32'hFFFF_FFFF, 4'hF,    c_decerr, 32'h0);
        add_vec("r_reg0",     0, 16'h0000, 32'h0,         4'h0,    c_okay,   32'h0102_0304);
        add_vec("r_top",      0, 16'hFFFC, 32'h0,         4'h0,    c_decerr, 32'hDEAD_BEEF);

        foreach (vecs[k]) begin
            if (vecs[k].is_wr) begin
                do_write(vecs[k].addr, vecs[k].wdata, vecs[k].wstrb, rsp, lat);
                chk({vecs[k].name, "_lat"},  32'(lat), 32'd1);
                chk({vecs[k].name, "_resp"}, 32'(rsp), 32'(vecs[k].exp_resp));
            end else begin
                do_read(vecs[k].addr, rd, rsp, lat);
                chk({vecs[k].name, "_lat"},  32'(lat), 32'd1);
                chk({vecs[k].name, "_resp"}, 32'(rsp), 32'(vecs[k].exp_resp));
                chk({vecs[k].name, "_data"}, rd, vecs[k].exp_rdata);
            end
        end

        // ---------------- AW ahead of W by two cycles, partial strobe
        s_awvalid = 1'b1; s_awaddr = 16'h0018;
        @(posedge clk_main_a0); #1 s_awvalid = 1'b0;
        @(posedge clk_main_a0); #1;
        s_wvalid = 1'b1; s_wdata = 32'hFACE_B00C; s_wstrb = 4'b1100;
        @(posedge clk_main_a0); #1 s_wvalid = 1'b0;
        chk("aw1st_b_not_yet", 32'(s_bvalid), 32'd0);
        @(posedge clk_main_a0); #1;
        chk("aw1st_bvalid", 32'(s_bvalid), 32'd1);
        chk("aw1st_bresp", 32'(s_bresp), 32'(c_okay));
        chk("aw1st_pulse", 32'(wr_pulse), 32'h40);
        chk("aw1st_reg6", rw_regs[223:192], 32'hFACE_0000);
        @(posedge clk_main_a0); #1;

        // ---------------- zero-strobe write still pulses
        s_awvalid = 1'b1; s_awaddr = 16'h0018;
        s_wvalid  = 1'b1; s_wdata = 32'hFFFF_FFFF; s_wstrb = 4'h0;
        @(posedge clk_main_a0); #1 s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(posedge clk_main_a0); #1;
        chk("s0_pulse", 32'(wr_pulse), 32'h40);
        chk("s0_reg6", rw_regs[223:192], 32'hFACE_0000);
        @(posedge clk_main_a0); #1;

        // ---------------- full register image
        exp_rw = '{32'h0102_0304, 32'h12BB_56DD, 32'h0, 32'h0,
                   32'h0, 32'h0, 32'hFACE_0000, 32'h89AB_CDEF};
        for (int i = 0; i < NUM_RW; i++) begin
            chk($sformatf("img_reg%0d", i), rw_regs[i*32 +: 32], exp_rw[i]);
        end

        // ---------------- read backpressure
        s_rready = 1'b0;
        s_arvalid = 1'b1; s_araddr = 16'h0030;
        @(posedge clk_main_a0); #1 s_arvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_vld_rdy_%0d", c), {30'd0, s_rvalid, s_arready}, 32'd2);
            chk($sformatf("bp_data_%0d", c), s_rdata, 32'hDEAD_BEEF);
            chk($sformatf("bp_resp_%0d", c), 32'(s_rresp), 32'(c_decerr));
            @(posedge clk_main_a0); #1;
        end
        s_rready = 1'b1;
        @(posedge clk_main_a0); #1;
        chk("bp_release", {s_rvalid, s_rresp, s_rdata[28:0]}, 32'd0);
        chk("bp_rdata_clr", s_rdata, 32'd0);

        // ---------------- read accepted on the commit edge sees old data
        s_awvalid = 1'b1; s_awaddr = 16'h0008;
        s_wvalid  = 1'b1; s_wdata = 32'h5555_AAAA; s_wstrb = 4'hF;
        @(posedge clk_main_a0); #1 s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_arvalid = 1'b1; s_araddr = 16'h0008;
        @(posedge clk_main_a0); #1 s_arvalid = 1'b0;
        chk("same_bvalid", 32'(s_bvalid), 32'd1);
        chk("same_rvalid", 32'(s_rvalid), 32'd1);
        chk("same_old_data", s_rdata, 32'h0);
        chk("same_reg2_new", rw_regs[95:64], 32'h5555_AAAA);
        @(posedge clk_main_a0); #1;
        do_read(16'h0008, rd, rsp, lat);
        chk("same_reread", rd, 32'h5555_AAAA);

        // ---------------- reset drops a half-received write
        s_wvalid = 1'b1; s_wdata = 32'h7777_7777; s_wstrb = 4'hF;
        @(posedge clk_main_a0); #1 s_wvalid = 1'b0;
        rst_main = 1'b1;
        @(posedge clk_main_a0); #1 rst_main = 1'b0;
        chk("mrst_rw_zero", 32'(|rw_regs), 32'd0);
        s_awvalid = 1'b1; s_awaddr = 16'h0008;
        @(posedge clk_main_a0); #1 s_awvalid = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (s_bvalid) seen = 1;
            @(posedge clk_main_a0); #1;
        end
        chk("mrst_no_b", 32'(seen), 32'd0);
        s_wvalid = 1'b1; s_wdata = 32'h0000_00AB; s_wstrb = 4'h1;
        @(posedge clk_main_a0); #1 s_wvalid = 1'b0;
        @(posedge clk_main_a0); #1;
        chk("mrst_bvalid", 32'(s_bvalid), 32'd1);
        chk("mrst_reg2", rw_regs[95:64], 32'h0000_00AB);
        @(posedge clk_main_a0); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
